// File: rtl/data_memory.sv
// Word-addressed data memory answering the core's DM_* interface: combinational read,
// synchronous write, post-reset zero-fill, a side load port and status reporting.
module data_memory #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4096,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DM_enable,
    input  logic                  DM_read,
    input  logic                  DM_write,
    input  logic [ADDR_WIDTH-1:0] DM_address,
    input  logic [DATA_WIDTH-1:0] DM_in,
    output logic [DATA_WIDTH-1:0] DM_out,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy,
    output logic                  access_err,
    output logic [15:0]           wr_count
);

    localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      clr_addr_q, clr_addr_d;
    logic                  err_q, err_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  run;
    logic                  rd;
    logic                  wr;
    logic                  cpu_in_range;
    logic                  ld_in_range;
    logic                  ld_fire;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Gating with rst keeps every access and the load handshake quiet while reset is held.
    assign run          = rst & (state_q == ST_RUN);
    assign rd           = run & DM_enable & DM_read;
    assign wr           = run & DM_enable & DM_write;
    assign cpu_in_range = ({1'b0, DM_address} < DEPTH_A);
    assign ld_in_range  = ({1'b0, ld_addr} < DEPTH_A);
    assign ld_ready     = run & ~wr;
    assign ld_fire      = ld_valid & ld_ready;

    assign DM_out     = (rd & cpu_in_range) ? mem_q[DM_address[IDX_W-1:0]] : '0;
    assign busy       = ~rst | (state_q == ST_CLEAR);
    assign access_err = err_q;
    assign wr_count   = wr_count_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        err_d      = err_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        if (rst) begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we     = 1'b1;
                    clr_addr_d = clr_addr_q + IDX_W'(1);
                    if (clr_addr_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // CPU write and load transfer never coincide: ld_ready is low whenever wr is high.
                    if (wr) begin
                        if (cpu_in_range) begin
                            mem_we    = 1'b1;
                            mem_waddr = DM_address[IDX_W-1:0];
                            mem_wdata = DM_in;
                            if (wr_count_q != 16'hFFFF) begin
                                wr_count_d = wr_count_q + 16'd1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (rd & (wr | ~cpu_in_range)) begin
                        err_d = 1'b1;
                    end
                    if (ld_fire) begin
                        if (ld_in_range) begin
                            mem_we    = 1'b1;
                            mem_waddr = ld_addr[IDX_W-1:0];
                            mem_wdata = ld_data;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomised and directed bench for data_memory against a word-array reference model,
// with a queue-based scoreboard checked on the falling edge.
module tb_data_memory;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          DM_enable, DM_read, DM_write;
    logic [AW-1:0] DM_address;
    logic [DW-1:0] DM_in;
    logic [DW-1:0] DM_out;
    logic          ld_valid, ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          busy, access_err;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    data_memory #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .DM_enable (DM_enable),
        .DM_read   (DM_read),
        .DM_write  (DM_write),
        .DM_address(DM_address),
        .DM_in     (DM_in),
        .DM_out    (DM_out),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .busy      (busy),
        .access_err(access_err),
        .wr_count  (wr_count)
    );

    typedef struct packed {
        logic [DW-1:0] dm_out;
        logic          busy;
        logic          ld_ready;
        logic          err;
        logic [15:0]   wrc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    // Reference model: a plain word array plus the status it implies.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_run;
    int            m_fill_left;
    bit            m_err;
    int            m_cnt;
    bit            m_ready;

    task automatic step(input logic r, input logic en, input logic rdb, input logic wrb,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                        input bit chk, input string nm);
        exp_t e;
        bit   rd_b, wr_b, a_ok, la_ok;
        rst        = r;
        DM_enable  = en;
        DM_read    = rdb;
        DM_write   = wrb;
        DM_address = a;
        DM_in      = d;
        ld_valid   = lv;
        ld_addr    = la;
        ld_data    = ldd;
        rd_b  = en && rdb;
        wr_b  = en && wrb;
        a_ok  = int'(a) < DEPTH;
        la_ok = int'(la) < DEPTH;
        e.busy     = !r || !m_run;
        e.ld_ready = r && m_run && !wr_b;
        if (r && m_run && rd_b && a_ok) e.dm_out = m_mem[int'(a)];
        else                            e.dm_out = '0;
        e.err = m_err;
        e.wrc = 16'(m_cnt);
        m_ready = e.ld_ready;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        if (!r) begin
            m_run       = 1'b0;
            m_fill_left = DEPTH;
            m_err       = 1'b0;
            m_cnt       = 0;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (!m_run) begin
            m_fill_left--;
            if (m_fill_left == 0) m_run = 1'b1;
        end else begin
            if (wr_b) begin
                if (a_ok) begin
                    m_mem[int'(a)] = d;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (rd_b && (wr_b || !a_ok)) m_err = 1'b1;
            if (lv && !wr_b) begin
                if (la_ok) m_mem[int'(la)] = ldd;
                else       m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic r, input bit chk, input string nm);
        step(r, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, chk, nm);
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input string nm);
        step(1'b1, 1'b1, 1'b1, 1'b0, a, '0, 1'b0, '0, '0, 1'b1, nm);
    endtask

    task automatic fill_run(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0,
                 1'b0, '0, '0, 1'b1, nm);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  got;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got.dm_out   = DM_out;
            got.busy     = busy;
            got.ld_ready = ld_ready;
            got.err      = access_err;
            got.wrc      = wr_count;
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("FAIL %s @%0t: got out=%h busy=%b ld_ready=%b err=%b cnt=%0d, expected out=%h busy=%b ld_ready=%b err=%b cnt=%0d",
                         nm, $time, got.dm_out, got.busy, got.ld_ready, got.err, got.wrc,
                         e.dm_out, e.busy, e.ld_ready, e.err, e.wrc);
            end
        end
    end

    initial begin
        logic          lv_h;
        logic [AW-1:0] la_h;
        logic [DW-1:0] ld_h;

        // Reset for two cycles; the second is checked after the first reset edge.
        idle(1'b0, 1'b0, "reset0");
        step(1'b0, 1'b1, 1'b1, 1'b1, AW'(16), 32'h1234, 1'b1, AW'(5), 32'h55, 1'b1, "reset_state");

        // Zero-fill: writes and loads offered throughout must be ignored, busy high exactly DEPTH cycles.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 1'b1, ($urandom_range(0, 2) == 0), AW'(i), $urandom(),
                 ($urandom_range(0, 1) == 1), AW'($urandom_range(0, DEPTH - 1)), $urandom(),
                 1'b1, "fill");
        end
        fill_run(16, "post_fill_zero");

        // Write then read back at 0x010.
        step(1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, "wr_010");
        rd_chk(12'h010, "rd_010");

        // CPU write wins over a simultaneous load; the held load lands next cycle.
        step(1'b1, 1'b1, 1'b0, 1'b1, 12'h020, 32'hA5A5_0020, 1'b1, 12'h021, 32'h0BAD_F00D, 1'b1, "ld_blocked");
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h021, 32'h0BAD_F00D, 1'b1, "ld_accept");
        rd_chk(12'h020, "rd_020");
        rd_chk(12'h021, "rd_021");

        // Read and write together: pre-write data shown, error raised and sticky.
        step(1'b1, 1'b1, 1'b0, 1'b1, 12'h030, 32'h1, 1'b0, '0, '0, 1'b1, "wr_030_old");
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h030, 32'h2, 1'b0, '0, '0, 1'b1, "rdwr_030");
        rd_chk(12'h030, "rd_030_new");
        idle(1'b1, 1'b1, "err_sticky");

        // Out-of-range write and read just past the implemented words.
        step(1'b1, 1'b1, 1'b0, 1'b1, 12'h400, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b1, "wr_oob");
        rd_chk(12'h400, "rd_oob");
        rd_chk(12'h3FF, "rd_last_word");

        // Reset during the fill after 100 cycles restarts it from the beginning.
        idle(1'b0, 1'b1, "reset_again");
        for (int i = 0; i < 100; i++) idle(1'b1, 1'b1, "fill_partial");
        idle(1'b0, 1'b1, "reset_midfill");
        for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b1, "fill_restart");
        fill_run(8, "post_refill_zero");

        // Random traffic with a load requester that holds its request until accepted.
        lv_h = 1'b0;
        la_h = '0;
        ld_h = '0;
        for (int i = 0; i < 2000; i++) begin
            logic          en, rdb, wrb;
            logic [AW-1:0] a;
            int            op, pick;
            en   = ($urandom_range(0, 9) != 0);
            op   = $urandom_range(0, 99);
            rdb  = (op < 45) || (op >= 85 && op < 87);
            wrb  = (op >= 45 && op < 87);
            pick = $urandom_range(0, 99);
            if (pick < 2)       a = AW'(DEPTH + $urandom_range(0, 4095 - DEPTH));
            else if (pick < 6)  a = AW'(DEPTH - 1);
            else                a = AW'($urandom_range(0, 15));
            if (!lv_h) begin
                lv_h = ($urandom_range(0, 2) == 0);
                la_h = ($urandom_range(0, 99) < 2) ? AW'(DEPTH + $urandom_range(0, 100))
                                                   : AW'($urandom_range(0, 15));
                ld_h = $urandom();
            end
            step(1'b1, en, rdb, wrb, a, $urandom(), lv_h, la_h, ld_h, 1'b1, "random");
            if (lv_h && m_ready) lv_h = 1'b0;
        end
        for (int i = 0; i < 16; i++) rd_chk(AW'(i), "final_readback");

        idle(1'b1, 1'b0, "drain");
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
